// File: rtl/bit_count_display.sv
// Counts ones/zeros or leading/trailing zeros of a captured operand one bit per
// cycle, converts both counts to BCD by shift-add-3 and drives four 7-segment digits.
module bit_count_display #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] operand,
    output logic             busy,
    output logic             done,
    output logic [6:0]       disp_a1,
    output logic [6:0]       disp_a0,
    output logic [6:0]       disp_b1,
    output logic [6:0]       disp_b0
);

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        CONVERT,
        DONE
    } state_t;

    localparam logic [6:0] LAST_BIT  = 7'(WIDTH - 1);
    localparam logic [6:0] LAST_STEP = 7'd6;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_ZERO  = 7'b0111111;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] shreg;
    logic             mode_q;
    logic             seen_one;
    logic [6:0]       step;
    logic [6:0]       count_a;
    logic [6:0]       count_b;
    logic [7:0]       bcd_a;
    logic [7:0]       bcd_b;
    logic [7:0]       next_bcd_a;
    logic [7:0]       next_bcd_b;
    logic             msb;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    function automatic logic [7:0] dabble(input logic [7:0] bcd, input logic bit_in);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = add3(bcd[7:4]);
        lo = add3(bcd[3:0]);
        return {hi[2:0], lo, bit_in};
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // A leading zero in the tens position is suppressed.
    function automatic logic [6:0] tens_seg(input logic [3:0] d);
        return (d == 4'd0) ? SEG_BLANK : seg7(d);
    endfunction

    assign msb        = shreg[WIDTH-1];
    assign next_bcd_a = dabble(bcd_a, count_a[6]);
    assign next_bcd_b = dabble(bcd_b, count_b[6]);
    assign busy       = (state == COUNT) || (state == CONVERT);
    assign done       = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = COUNT;
            COUNT:   if (step == LAST_BIT) next_state = CONVERT;
            CONVERT: if (step == LAST_STEP) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg    <= '0;
            mode_q   <= 1'b0;
            seen_one <= 1'b0;
            step     <= '0;
            count_a  <= '0;
            count_b  <= '0;
            bcd_a    <= '0;
            bcd_b    <= '0;
            disp_a1  <= SEG_BLANK;
            disp_a0  <= SEG_ZERO;
            disp_b1  <= SEG_BLANK;
            disp_b0  <= SEG_ZERO;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg    <= operand;
                        mode_q   <= mode;
                        seen_one <= 1'b0;
                        step     <= '0;
                        count_a  <= '0;
                        count_b  <= '0;
                        bcd_a    <= '0;
                        bcd_b    <= '0;
                    end
                end
                COUNT: begin
                    shreg <= {shreg[WIDTH-2:0], 1'b0};
                    step  <= (step == LAST_BIT) ? 7'd0 : step + 7'd1;
                    if (!mode_q) begin
                        if (msb) count_a <= count_a + 7'd1;
                        else     count_b <= count_b + 7'd1;
                    end else if (msb) begin
                        seen_one <= 1'b1;
                        count_b  <= '0;
                    end else begin
                        // B restarts at every 1 so it ends as the trailing-zero run.
                        count_b <= count_b + 7'd1;
                        if (!seen_one) count_a <= count_a + 7'd1;
                    end
                end
                CONVERT: begin
                    bcd_a   <= next_bcd_a;
                    bcd_b   <= next_bcd_b;
                    count_a <= {count_a[5:0], 1'b0};
                    count_b <= {count_b[5:0], 1'b0};
                    step    <= step + 7'd1;
                    if (step == LAST_STEP) begin
                        disp_a1 <= tens_seg(next_bcd_a[7:4]);
                        disp_a0 <= seg7(next_bcd_a[3:0]);
                        disp_b1 <= tens_seg(next_bcd_b[7:4]);
                        disp_b0 <= seg7(next_bcd_b[3:0]);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bit_count_display.sv
// Randomised self-checking bench for bit_count_display at WIDTH=16 and WIDTH=99,
// compared against a plain-arithmetic reference model.
module tb_bit_count_display;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mode;
    logic [15:0] operand;
    logic        busy;
    logic        done;
    logic [6:0]  disp_a1;
    logic [6:0]  disp_a0;
    logic [6:0]  disp_b1;
    logic [6:0]  disp_b0;

    logic        start_w;
    logic        mode_w;
    logic [98:0] operand_w;
    logic        busy_w;
    logic        done_w;
    logic [6:0]  wide_a1;
    logic [6:0]  wide_a0;
    logic [6:0]  wide_b1;
    logic [6:0]  wide_b0;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [6:0] pat [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                             7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

    always #5 clk = ~clk;

    bit_count_display #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .operand(operand),
        .busy(busy), .done(done),
        .disp_a1(disp_a1), .disp_a0(disp_a0), .disp_b1(disp_b1), .disp_b0(disp_b0)
    );

    bit_count_display #(.WIDTH(99)) dut_wide (
        .clk(clk), .rst(rst), .start(start_w), .mode(mode_w), .operand(operand_w),
        .busy(busy_w), .done(done_w),
        .disp_a1(wide_a1), .disp_a0(wide_a0), .disp_b1(wide_b1), .disp_b0(wide_b0)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Reference: counts straight from the definition of each mode.
    function automatic void model(input logic [98:0] v, input int w, input bit md,
                                  output int a, output int b);
        int ones = 0;
        int hi   = -1;
        int lo   = -1;
        for (int i = 0; i < w; i++) begin
            if (v[i]) begin
                ones++;
                if (lo < 0) lo = i;
                hi = i;
            end
        end
        if (!md) begin
            a = ones;
            b = w - ones;
        end else if (ones == 0) begin
            a = w;
            b = w;
        end else begin
            a = w - 1 - hi;
            b = lo;
        end
    endfunction

    function automatic logic [6:0] tens_exp(input int v);
        return (v / 10 == 0) ? 7'b0000000 : pat[v / 10];
    endfunction

    function automatic logic [6:0] units_exp(input int v);
        return pat[v % 10];
    endfunction

    // Cycle 0 is the cycle start is driven; done must appear in cycle 24.
    task automatic applyStimulus(input logic [15:0] op, input bit md, input bit extra_starts);
        int a;
        int b;
        int n;
        bit busy_ok;
        model(99'(op), 16, md, a, b);
        @(negedge clk);
        operand = op;
        mode    = md;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        operand = 16'($urandom);
        mode    = ~md;
        checkOutput("busy_after_start", 32'(busy), 32'd1);
        n       = 1;
        busy_ok = 1'b1;
        while (!done && n < 60) begin
            start = extra_starts && (n == 3 || n == 20);
            @(negedge clk);
            n++;
            if (!done && !busy) busy_ok = 1'b0;
        end
        start = 1'b0;
        checkOutput("latency", 32'(n), 32'd24);
        checkOutput("busy_during_op", 32'(busy_ok), 32'd1);
        checkOutput("busy_low_at_done", 32'(busy), 32'd0);
        checkOutput("disp_a1", 32'(disp_a1), 32'(tens_exp(a)));
        checkOutput("disp_a0", 32'(disp_a0), 32'(units_exp(a)));
        checkOutput("disp_b1", 32'(disp_b1), 32'(tens_exp(b)));
        checkOutput("disp_b0", 32'(disp_b0), 32'(units_exp(b)));
        if (extra_starts) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("done_one_cycle", 32'(done), 32'd0);
        checkOutput("start_in_done_ignored", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("hold_a", 32'({disp_a1, disp_a0}), 32'({tens_exp(a), units_exp(a)}));
        checkOutput("hold_b", 32'({disp_b1, disp_b0}), 32'({tens_exp(b), units_exp(b)}));
        checkOutput("idle_after_hold", 32'({busy, done}), 32'd0);
    endtask

    task automatic applyWideStimulus(input logic [98:0] op, input bit md);
        int a;
        int b;
        int n;
        model(op, 99, md, a, b);
        @(negedge clk);
        operand_w = op;
        mode_w    = md;
        start_w   = 1'b1;
        @(negedge clk);
        start_w   = 1'b0;
        operand_w = '0;
        n = 1;
        while (!done_w && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("wide_latency", 32'(n), 32'd107);
        checkOutput("wide_a1", 32'(wide_a1), 32'(tens_exp(a)));
        checkOutput("wide_a0", 32'(wide_a0), 32'(units_exp(a)));
        checkOutput("wide_b1", 32'(wide_b1), 32'(tens_exp(b)));
        checkOutput("wide_b0", 32'(wide_b0), 32'(units_exp(b)));
        @(negedge clk);
    endtask

    initial begin
        int n;
        int gap;
        bit saw_done;
        logic [15:0] r16;
        logic [127:0] r128;

        rst       = 1'b1;
        start     = 1'b0;
        mode      = 1'b0;
        operand   = '0;
        start_w   = 1'b0;
        mode_w    = 1'b0;
        operand_w = '0;
        #12;
        checkOutput("reset_busy_done", 32'({busy, done, busy_w, done_w}), 32'd0);
        checkOutput("reset_tens", 32'({disp_a1, disp_b1}), 32'd0);
        checkOutput("reset_units", 32'({disp_a0, disp_b0}), 32'({7'b0111111, 7'b0111111}));
        checkOutput("reset_wide_units", 32'({wide_a0, wide_b0}), 32'({7'b0111111, 7'b0111111}));
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(16'h00F0, 1'b0, 1'b0);
        applyStimulus(16'h00F0, 1'b1, 1'b0);
        applyStimulus(16'h0000, 1'b1, 1'b0);
        applyStimulus(16'hFFFF, 1'b0, 1'b1);

        // Abort mid-COUNT; previous result had a non-blank tens digit.
        @(negedge clk);
        operand = 16'hA5A5;
        mode    = 1'b0;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("abort_busy_done", 32'({busy, done}), 32'd0);
        checkOutput("abort_disp", 32'({disp_a1, disp_a0, disp_b1, disp_b0}),
                    32'({7'b0, 7'b0111111, 7'b0, 7'b0111111}));
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        checkOutput("abort_no_done", 32'(saw_done), 32'd0);
        applyStimulus(16'h8001, 1'b1, 1'b0);

        // start held high: second capture on the first edge back in IDLE.
        @(negedge clk);
        operand = 16'h0F0F;
        mode    = 1'b0;
        start   = 1'b1;
        n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        gap = 0;
        @(negedge clk);
        while (!done && gap < 60) begin
            @(negedge clk);
            gap++;
        end
        start = 1'b0;
        checkOutput("back_to_back_period", 32'(gap + 1), 32'd25);
        checkOutput("back_to_back_a0", 32'(disp_a0), 32'(pat[8]));
        checkOutput("back_to_back_b0", 32'(disp_b0), 32'(pat[8]));
        repeat (3) @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            r16 = 16'($urandom);
            if (i % 2 == 1) r16 = r16 << $urandom_range(0, 15);
            else            r16 = r16 >> $urandom_range(0, 15);
            applyStimulus(r16, 1'($urandom_range(0, 1)), 1'b0);
        end

        applyWideStimulus({99{1'b1}}, 1'b0);
        r128 = {$urandom, $urandom, $urandom, $urandom};
        applyWideStimulus(r128[98:0] >> $urandom_range(0, 60), 1'b1);
        applyWideStimulus('0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bit_count_display.md
BIT_COUNT_DISPLAY -- requirements
Module: bit_count_display

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, giving the operand width in bits; the legal range is 2..99.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The module SHALL have port start, input, 1 bit: request to begin an operation, sampled only in IDLE.
REQ-005 The module SHALL have port mode, input, 1 bit: 0 selects the ones/zeros count, 1 selects the leading-zeros/trailing-zeros count.
REQ-006 The module SHALL have port operand, input, WIDTH bits: the value to analyse, captured with start.
REQ-007 The module SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-008 The module SHALL have port done, output, 1 bit: a one-cycle pulse when a new result is shown.
REQ-009 The module SHALL have ports disp_a1 and disp_a0, outputs, 7 bits each: the tens and units digits of result A.
REQ-010 The module SHALL have ports disp_b1 and disp_b0, outputs, 7 bits each: the tens and units digits of result B.

Function
REQ-011 The display ports SHALL use active-high segments, bit0=a ... bit6=g; blank = 7'b0000000.
REQ-012 Digit patterns SHALL be:
- 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
- 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
REQ-013 The FSM SHALL have states IDLE, COUNT, CONVERT and DONE; reset state is IDLE.
REQ-014 In IDLE, start=1 at a rising edge SHALL capture operand and mode, clear the counters, set busy=1 and enter COUNT.
REQ-015 Later changes on operand and mode SHALL be ignored until the next capture.
REQ-016 COUNT SHALL last exactly WIDTH cycles and examine one captured bit per cycle, MSB first.
REQ-017 Mode 0 in COUNT:
- A = number of 1 bits.
- B = WIDTH - A.
REQ-018 Mode 1 in COUNT:
- A = number of 0 bits above the most significant 1.
- B = number of 0 bits below the least significant 1.
- An all-zero operand SHALL give A = B = WIDTH.
REQ-019 Counters SHALL be 7 bits wide and SHALL never exceed WIDTH; no wrap-around is possible in the legal WIDTH range.
REQ-020 CONVERT SHALL last exactly 7 cycles and convert A and B to two-digit BCD sequentially (shift-add-3), both in parallel.
REQ-021 DONE SHALL last exactly one cycle, then return to IDLE. On entry to DONE:
- all four display registers update together;
- done=1 for that cycle;
- busy=0 from that cycle.
REQ-022 Latency from the start-sampling edge to done high SHALL be exactly WIDTH+8 clock cycles, independent of operand and mode.
REQ-023 The tens digit SHALL be blank when its value is 0; the units digit SHALL always be shown, including 0.
REQ-024 Displays SHALL hold the last result between operations; they are registered outputs with no combinational path from the inputs.
REQ-025 start while busy, or in the DONE cycle, SHALL be ignored and SHALL NOT be queued.
REQ-026 start held high continuously SHALL begin a new operation on the first edge after returning to IDLE (back-to-back period WIDTH+9 cycles).

Reset
REQ-027 While rst=1, the module SHALL asynchronously force:
- state = IDLE;
- busy = 0, done = 0;
- counters and BCD registers = 0;
- disp_a1 and disp_b1 blank;
- disp_a0 and disp_b0 show "0" (0111111).
REQ-028 Reset during COUNT or CONVERT SHALL abort the operation with no done pulse; the first start after rst falls SHALL behave as from power-up.

Verification (WIDTH=16 unless noted)
REQ-029 The bench SHALL cover these scenarios:
- mode=0, operand=16'h00F0 -> done 24 cycles after start; disp_a1 blank, disp_a0=1100110 (4), disp_b1=0000110, disp_b0=1011011 (12).
- mode=1, operand=16'h00F0 -> A=8 (disp_a0=1111111, tens blank); B=4 (disp_b0=1100110, tens blank).
- mode=1, operand=16'h0000 -> A=B=16; both tens=0000110, both units=1111101.
- mode=0, operand=16'hFFFF; start pulsed again at cycles 3 and 20 -> single done at 24; A=16, B=0 (disp_b1 blank, disp_b0=0111111).
- rst asserted at cycle 10 of COUNT -> busy=0 immediately, no done, reset display values; a later start completes normally.
- WIDTH=99, mode=0, all ones -> done after 107 cycles; A=99 (1101111/1101111), B=0.
